// File: rtl/gmsk_pkg.sv
// Shared encodings for the core sequencer: opcodes, ALU operation codes,
// sequencer state enumeration and the decode result record.
package gmsk_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_SUB     = 7'b0100000;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALT      = 3'd5
    } seq_state_e;

    typedef struct packed {
        logic    legal;
        alu_op_e alu_op;
        logic    alu_src_imm;
    } decode_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decode: classifies the instruction register as
// legal or not and derives the ALU operation and operand-B select.
module seq_decode
    import gmsk_pkg::*;
(
    input  logic [31:0] ir,
    output logic        legal,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    decode_t    dec;
    logic       unused_fields;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    // Register specifiers and the immediate body do not affect legality.
    assign unused_fields = ^{ir[24:15], ir[11:7]};

    always_comb begin
        dec.legal       = 1'b0;
        dec.alu_op      = ALU_ADD;
        dec.alu_src_imm = 1'b0;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        F3_ADD_SUB: begin dec.legal = 1'b1; dec.alu_op = ALU_ADD; end
                        F3_AND:     begin dec.legal = 1'b1; dec.alu_op = ALU_AND; end
                        F3_OR:      begin dec.legal = 1'b1; dec.alu_op = ALU_OR;  end
                        default:    dec.legal = 1'b0;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADD_SUB) begin
                    dec.legal  = 1'b1;
                    dec.alu_op = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                if (funct3 == F3_ADD_SUB) begin
                    dec.legal       = 1'b1;
                    dec.alu_op      = ALU_ADD;
                    dec.alu_src_imm = 1'b1;
                end
            end
            default: dec.legal = 1'b0;
        endcase
    end

    assign legal       = dec.legal;
    assign alu_op      = dec.alu_op;
    assign alu_src_imm = dec.alu_src_imm;

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/WRITEBACK with
// fetch timeout and sticky halt. Optional retire counter via GMSK_RETIRE_CNT_EN.
module core_sequencer
    import gmsk_pkg::*;
#(
    parameter int unsigned FETCH_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
`ifdef GMSK_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] instr_in,
    input  logic        stall_in,
    output logic [31:0] ir,
    output logic        pc_en,
    output logic        reg_write,
    output logic [1:0]  alu_op,
    output logic        alu_src_imm,
    output logic        halt,
    output logic        illegal,
    output logic        fetch_err
);

    localparam logic        TIMEOUT_EN   = (FETCH_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(FETCH_TIMEOUT) - 32'd1;

    seq_state_e  state_q, state_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;
    logic        load_ir;
    logic        set_illegal;
    logic        set_fetch_err;
    logic        dec_legal;
    logic [1:0]  dec_alu_op;
    logic        dec_alu_src_imm;
    logic        alu_valid;

    seq_decode u_decode (
        .ir          (ir),
        .legal       (dec_legal),
        .alu_op      (dec_alu_op),
        .alu_src_imm (dec_alu_src_imm)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            ir         <= '0;
            illegal    <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (load_ir) begin
                ir <= instr_in;
            end
            if (set_illegal) begin
                illegal <= 1'b1;
            end
            if (set_fetch_err) begin
                fetch_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        load_ir       = 1'b0;
        set_illegal   = 1'b0;
        set_fetch_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                state_d    = ST_FETCH;
                wait_cnt_d = '0;
            end
            ST_FETCH: begin
                // An ack on the final allowed cycle takes priority over the timeout.
                if (imem_ack) begin
                    load_ir    = 1'b1;
                    state_d    = ST_DECODE;
                    wait_cnt_d = '0;
                end else if (TIMEOUT_EN && wait_cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_HALT;
                    set_fetch_err = 1'b1;
                    wait_cnt_d    = '0;
                end else if (TIMEOUT_EN) begin
                    wait_cnt_d = wait_cnt_q + 32'd1;
                end
            end
            ST_DECODE: begin
                if (dec_legal) begin
                    state_d = ST_EXECUTE;
                end else begin
                    state_d     = ST_HALT;
                    set_illegal = 1'b1;
                end
            end
            ST_EXECUTE: begin
                if (!stall_in) begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_HALT:      state_d = ST_HALT;
            default:      state_d = ST_IDLE;
        endcase
    end

    assign alu_valid = (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);

    always_comb begin
        imem_req    = (state_q == ST_FETCH);
        reg_write   = (state_q == ST_WRITEBACK);
        pc_en       = (state_q == ST_WRITEBACK);
        halt        = (state_q == ST_HALT);
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        if (alu_valid) begin
            alu_op      = dec_alu_op;
            alu_src_imm = dec_alu_src_imm;
        end
    end

`ifdef GMSK_RETIRE_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (state_q == ST_WRITEBACK) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed corner cases plus randomized
// instructions checked against a table-driven decode model and latency rules.
module tb_core_sequencer;

    localparam int unsigned TMO = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] instr_in = '0;
    logic        stall_in = 1'b0;
    logic        imem_req;
    logic [31:0] ir;
    logic        pc_en;
    logic        reg_write;
    logic [1:0]  alu_op;
    logic        alu_src_imm;
    logic        halt;
    logic        illegal;
    logic        fetch_err;
`ifdef GMSK_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
    logic [31:0] exp_retire = '0;
`endif

    core_sequencer #(.FETCH_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef GMSK_RETIRE_CNT_EN
        .retire_cnt  (retire_cnt),
`endif
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr_in    (instr_in),
        .stall_in    (stall_in),
        .ir          (ir),
        .pc_en       (pc_en),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .halt        (halt),
        .illegal     (illegal),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Legal instruction patterns: word matches when (word & mask) == match.
    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [1:0]  op;
        logic        imm;
    } pat_t;

    pat_t pats [5];

    initial begin
        pats[0] = '{mask: 32'hFE00707F, match: 32'h00000033, op: 2'd0, imm: 1'b0}; // ADD
        pats[1] = '{mask: 32'hFE00707F, match: 32'h40000033, op: 2'd1, imm: 1'b0}; // SUB
        pats[2] = '{mask: 32'hFE00707F, match: 32'h00007033, op: 2'd2, imm: 1'b0}; // AND
        pats[3] = '{mask: 32'hFE00707F, match: 32'h00006033, op: 2'd3, imm: 1'b0}; // OR
        pats[4] = '{mask: 32'h0000707F, match: 32'h00000013, op: 2'd0, imm: 1'b1}; // ADDI
    end

    task automatic model_decode(input logic [31:0] w, output logic legal,
                                output logic [1:0] op, output logic imm);
        legal = 1'b0;
        op    = 2'd0;
        imm   = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if ((w & pats[k].mask) == pats[k].match) begin
                legal = 1'b1;
                op    = pats[k].op;
                imm   = pats[k].imm;
            end
        end
    endtask

    function automatic logic [31:0] gen_instr();
        int unsigned k;
        k = $urandom_range(0, 5);
        if (k < 5) return pats[k].match | ($urandom & ~pats[k].mask);
        return $urandom;
    endfunction

    function automatic logic [8:0] out_vec();
        return {imem_req, pc_en, reg_write, alu_op, alu_src_imm, halt, illegal, fetch_err};
    endfunction

    task automatic do_reset();
        rst      = 1'b0;
        imem_ack = 1'b0;
        stall_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(out_vec()), 32'd0);
        check("reset_ir", ir, 32'd0);
`ifdef GMSK_RETIRE_CNT_EN
        exp_retire = '0;
        check("reset_retire", retire_cnt, 32'd0);
`endif
        rst = 1'b1;
        @(negedge clk);
        check("fetch_after_reset", 32'(imem_req), 32'd1);
    endtask

    // Runs one instruction from a FETCH cycle; returns with the DUT back in
    // FETCH (legal) or in HALT (illegal).
    task automatic run_instr(input logic [31:0] instr, input int unsigned waits,
                             input int unsigned stalls, output logic was_legal);
        logic       legal;
        logic [1:0] op;
        logic       imm;
        model_decode(instr, legal, op, imm);
        was_legal = legal;
        for (int unsigned i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            instr_in = $urandom;
            @(negedge clk);
            check("fetch_wait", {30'd0, imem_req, halt}, 32'd2);
        end
        imem_ack = 1'b1;
        instr_in = instr;
        @(negedge clk);
        check("decode_ir", ir, instr);
        check("decode_outs", 32'(out_vec()), 32'd0);
        imem_ack = 1'($urandom);
        instr_in = $urandom;
        stall_in = (stalls != 0);
        @(negedge clk);
        if (!legal) begin
            check("illegal_flags", {28'd0, halt, illegal, fetch_err, reg_write}, 32'hC);
            stall_in = 1'b0;
            return;
        end
        check("exec_alu", {29'd0, alu_op, alu_src_imm}, {29'd0, op, imm});
        check("exec_no_wb", {30'd0, reg_write, pc_en}, 32'd0);
        for (int unsigned s = 1; s <= stalls; s++) begin
            imem_ack = 1'($urandom);
            @(negedge clk);
            check("stall_hold", {28'd0, reg_write, alu_op, alu_src_imm}, {28'd0, 1'b0, op, imm});
            if (s == stalls) stall_in = 1'b0;
        end
        @(negedge clk);
        check("wb_strobes", {29'd0, reg_write, pc_en, imem_req}, 32'd6);
        check("wb_alu", {29'd0, alu_op, alu_src_imm}, {29'd0, op, imm});
        check("wb_ir", ir, instr);
`ifdef GMSK_RETIRE_CNT_EN
        exp_retire = exp_retire + 32'd1;
`endif
        imem_ack = 1'b0;
        @(negedge clk);
        check("back_to_fetch", {29'd0, imem_req, reg_write, pc_en}, 32'd4);
`ifdef GMSK_RETIRE_CNT_EN
        check("retire_cnt", retire_cnt, exp_retire);
`endif
    endtask

    task automatic check_halted(input string tag, input int unsigned cycles);
        for (int unsigned c = 0; c < cycles; c++) begin
            imem_ack = 1'b1;
            instr_in = 32'h00000033;
            @(negedge clk);
            check(tag, {29'd0, halt, imem_req, reg_write | pc_en}, 32'd4);
        end
        imem_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ok;
        int unsigned cyc;

        // Reset release with ack held high: WRITEBACK on the fourth cycle.
        rst = 1'b0;
        imem_ack = 1'b1;
        instr_in = 32'h00500093;
        repeat (2) @(negedge clk);
        check("por_outputs", 32'(out_vec()), 32'd0);
        rst = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            cyc++;
            if (c == 1) check("min_lat_fetch", 32'(imem_req), 32'd1);
            if (c < 4)  check("min_lat_no_wb", 32'(reg_write), 32'd0);
        end
        check("min_lat_wb", {28'd0, reg_write, pc_en, alu_op, alu_src_imm}, 32'h19);
        check("min_lat_cycles", cyc, 32'd4);
        imem_ack = 1'b0;
        @(negedge clk);
        check("min_lat_refetch", 32'(imem_req), 32'd1);

        // SUB acked after three wait cycles.
        run_instr(32'h40208133, 3, 0, ok);

        // All-zero word is illegal.
        run_instr(32'h00000000, 0, 0, ok);
        check_halted("illegal_absorb", 4);
        check("illegal_sticky", {30'd0, illegal, fetch_err}, 32'd2);

        // Fetch timeout after TMO ack-less cycles.
        do_reset();
        for (int unsigned i = 0; i < TMO - 1; i++) begin
            @(negedge clk);
            check("tmo_wait", {30'd0, imem_req, halt}, 32'd2);
        end
        @(negedge clk);
        check("tmo_halt", {28'd0, halt, fetch_err, illegal, imem_req}, 32'hC);
        check_halted("tmo_absorb", 3);

        // Ack on the final allowed cycle wins over the timeout.
        do_reset();
        run_instr(32'h00A57533, TMO - 1, 0, ok);
        check("tmo_edge_no_err", {30'd0, fetch_err, halt}, 32'd0);

        // Reset asserted in the middle of a five-cycle stall.
        imem_ack = 1'b1;
        instr_in = 32'h00B50533;
        stall_in = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check("stall_mid", {29'd0, reg_write, alu_op}, 32'd0);
        #2 rst = 1'b0;
        #1;
        check("async_rst_outs", 32'(out_vec()), 32'd0);
        check("async_rst_ir", ir, 32'd0);
        stall_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
`ifdef GMSK_RETIRE_CNT_EN
        exp_retire = '0;
`endif
        @(negedge clk);
        check("post_rst_fetch", 32'(imem_req), 32'd1);
        run_instr(32'h00C5F633, 0, 2, ok);

`ifdef GMSK_RETIRE_CNT_EN
        force dut.retire_cnt = 32'hFFFFFFFF;
        #1 release dut.retire_cnt;
        exp_retire = 32'hFFFFFFFF;
        run_instr(32'h00000033, 0, 0, ok);
        check("retire_wrap", retire_cnt, 32'd0);
`endif

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            run_instr(gen_instr(), $urandom_range(0, 5), $urandom_range(0, 3), ok);
            if (!ok) begin
                check_halted("rand_halt", 2);
                do_reset();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
